// File: rtl/cla_nibble_seq_adder_if.sv
// cla_nibble_seq_adder_if: operand/result handshake bundle; op_sub exists only when CLA_SEQ_SUB_EN is defined
interface cla_nibble_seq_adder_if #(parameter int WIDTH = 16);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic in_cin;
`ifdef CLA_SEQ_SUB_EN
  logic op_sub;
`endif
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] out_sum;
  logic out_cout;
  logic out_ovf;
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
`ifdef CLA_SEQ_SUB_EN
    output op_sub,
`endif
    input in_ready, out_valid, out_sum, out_cout, out_ovf
  );
  modport slave (
    input in_valid, in_a, in_b, in_cin, out_ready,
`ifdef CLA_SEQ_SUB_EN
    input op_sub,
`endif
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );
endinterface

// File: rtl/cla_nibble_seq_adder.sv
// cla_nibble_seq_adder: drives an external 4-bit CLA one nibble per clock to add WIDTH-bit operands; CLA_SEQ_SUB_EN adds op_sub
module cla_nibble_seq_adder #(
  parameter int WIDTH = 16
) (
  input  logic clk,
  input  logic rst_n,
  cla_nibble_seq_adder_if.slave bus,
  output logic [3:0] cla_a,
  output logic [3:0] cla_b,
  output logic cla_cin,
  input  logic [3:0] cla_sum,
  input  logic cla_cout
);
  localparam int NIB = WIDTH / 4;
  localparam int CW = $clog2(NIB);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  if (WIDTH % 4 != 0 || WIDTH < 8) begin : g_bad_width
    $error("cla_nibble_seq_adder: WIDTH must be a multiple of 4 and at least 8");
  end
  logic [1:0] state;
  logic [WIDTH-1:0] a_r, b_r, sum_r, b_in;
  logic [CW-1:0] cnt;
  logic c_r, sa, sb, c_in;
  logic run, done;
`ifdef CLA_SEQ_SUB_EN
  assign b_in = bus.op_sub ? ~bus.in_b : bus.in_b;
  assign c_in = bus.op_sub | bus.in_cin;
`else
  assign b_in = bus.in_b;
  assign c_in = bus.in_cin;
`endif
  assign run = state == RUN;
  assign done = state == DONE;
  always_comb begin
    bus.in_ready = state == IDLE;
    bus.out_valid = done;
    bus.out_sum = done ? sum_r : '0;
    bus.out_cout = done & c_r;
    bus.out_ovf = done & (sa == sb) & (sum_r[WIDTH-1] != sa);
    cla_a = run ? a_r[3:0] : 4'd0;
    cla_b = run ? b_r[3:0] : 4'd0;
    cla_cin = run & c_r;
  end
  // sum fills from the top so nibble 0 lands at the bottom after NIB shifts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      sum_r <= '0;
      c_r <= 1'b0;
      sa <= 1'b0;
      sb <= 1'b0;
      cnt <= '0;
    end else if (state == IDLE && bus.in_valid) begin
      a_r <= bus.in_a;
      b_r <= b_in;
      c_r <= c_in;
      sa <= bus.in_a[WIDTH-1];
      sb <= b_in[WIDTH-1];
      cnt <= '0;
      state <= RUN;
    end else if (run) begin
      sum_r <= {cla_sum, sum_r[WIDTH-1:4]};
      a_r <= a_r >> 4;
      b_r <= b_r >> 4;
      c_r <= cla_cout;
      cnt <= cnt + 1'b1;
      if (cnt == CW'(NIB - 1)) state <= DONE;
    end else if (done && bus.out_ready) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_cla_nibble_seq_adder.sv
// tb_cla_nibble_seq_adder: directed ops against a behavioural 4-bit CLA with a result scoreboard
module tb_cla_nibble_seq_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] cla_a, cla_b, cla_sum;
  logic cla_cin, cla_cout;
  int checks = 0;
  int errors = 0;
  logic [17:0] q[$];
  cla_nibble_seq_adder_if #(.WIDTH(16)) bus();
  cla_nibble_seq_adder #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave),
    .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin),
    .cla_sum(cla_sum), .cla_cout(cla_cout)
  );
  always #5 clk = ~clk;
  assign {cla_cout, cla_sum} = 5'(cla_a) + 5'(cla_b) + 5'(cla_cin);
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub, input int hold);
    logic [15:0] bb;
    logic c;
    logic [16:0] full;
    logic [17:0] exp, snap;
    int lat;
    bb = sub ? ~b : b;
    c = sub ? 1'b1 : cin;
    full = 17'(a) + 17'(bb) + 17'(c);
    q.push_back({full[16], full[15:0], (a[15] == bb[15]) && (full[15] != a[15])});
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_cin = cin;
`ifdef CLA_SEQ_SUB_EN
    bus.op_sub = sub;
`endif
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("in_ready_run", 32'(bus.in_ready), 32'd0);
    check("cla_a_nib0", 32'(cla_a), 32'(a[3:0]));
    check("cla_b_nib0", 32'(cla_b), 32'(bb[3:0]));
    check("cla_cin_nib0", 32'(cla_cin), 32'(c));
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd4);
    if (!bus.out_valid) return;
    snap = {bus.out_cout, bus.out_sum, bus.out_ovf};
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_stable", 32'({bus.out_cout, bus.out_sum, bus.out_ovf}), 32'(snap));
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    exp = q.pop_front();
    check("out_sum", 32'(bus.out_sum), 32'(exp[16:1]));
    check("out_cout", 32'(bus.out_cout), 32'(exp[17]));
    check("out_ovf", 32'(bus.out_ovf), 32'(exp[0]));
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("in_ready_after", 32'(bus.in_ready), 32'd1);
    check("valid_dropped", 32'(bus.out_valid), 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_cin = 1'b0;
    bus.out_ready = 1'b0;
`ifdef CLA_SEQ_SUB_EN
    bus.op_sub = 1'b0;
`endif
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_sum", 32'(bus.out_sum), 32'd0);
    check("rst_out_flags", 32'({bus.out_cout, bus.out_ovf}), 32'd0);
    check("rst_cla", 32'({cla_a, cla_b, cla_cin}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
    do_op(16'h7FFF, 16'h0000, 1'b1, 1'b0, 0);
    do_op(16'h8000, 16'h8000, 1'b0, 1'b0, 6);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a = 16'hABCD;
    bus.in_b = 16'h1111;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(bus.in_ready), 32'd1);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_out_sum", 32'(bus.out_sum), 32'd0);
    check("abort_cla", 32'({cla_a, cla_b, cla_cin}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_result", 32'(bus.out_valid), 32'd0);
    do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 1);
`ifdef CLA_SEQ_SUB_EN
    do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
    do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 2);
`endif
    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cla_nibble_seq_adder.md
Name: cla_nibble_seq_adder

Overview:
- Multi-cycle wide adder sequencer that sits on both sides of the 4-bit carry-lookahead adder.
- Accepts WIDTH-bit operands over a valid/ready handshake and feeds them to the external 4-bit CLA one nibble per cycle, LSB nibble first.
- Captures each CLA sum nibble and carry-out, and returns the full WIDTH-bit result through a valid/ready output handshake.
- Lets a single small CLA serve wide datapaths (16/32-bit) at one nibble per clock.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8 (elaboration error otherwise).
- NIB, WIDTH/4, derived local constant: number of RUN cycles per operation.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept operands.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- in_cin  input  1  carry-in for nibble 0.
- cla_a  output  4  A nibble to the CLA.
- cla_b  output  4  B nibble to the CLA.
- cla_cin  output  1  carry-in to the CLA.
- cla_sum  input  4  CLA sum nibble (combinational return).
- cla_cout  input  1  CLA carry-out.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_sum  output  WIDTH  result.
- out_cout  output  1  final carry-out.
- out_ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, counter=0, carry register=0, operand registers=0, cla_a/cla_b/cla_cin=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready at an edge: latch in_a, in_b and the carry register (<= in_cin); latch sign bits in_a[WIDTH-1] and in_b[WIDTH-1]; counter=0; go to RUN.
- RUN:
  - in_ready=0.
  - cla_a/cla_b = low nibble of the operand shift registers; cla_cin = carry register.
  - Each edge: shift cla_sum into the top nibble of the sum shift register (right shift); shift the operand registers right by 4; carry register <= cla_cout; counter++.
  - After the NIB-th RUN edge: go to DONE.
- DONE:
  - out_valid=1; out_sum = assembled sum; out_cout = carry register.
  - out_ovf = (signA == signB) & (out_sum[WIDTH-1] != signA).
  - Outputs stay stable while out_valid=1 & out_ready=0.
  - On out_ready: go to IDLE and drop out_valid.
- CLA drive: cla_a/cla_b/cla_cin are 0 in IDLE and DONE.
- Latency: out_valid rises exactly NIB edges after the accept edge. With WIDTH=16, accept at edge E0 gives out_valid high after edge E4.
- Throughput: one op per NIB+2 cycles minimum (no overlap; in_ready low in RUN and DONE).
- in_valid during RUN/DONE: ignored; the producer must hold it.
- out_ready held high at DONE entry: one-cycle out_valid pulse, then IDLE.
- Wrap-around: the final carry is reported only via out_cout; out_sum is modulo 2^WIDTH.
- Reset mid-RUN or mid-DONE: operation aborted, no result emitted, returns to IDLE immediately.

Optional Feature:
- Macro: CLA_SEQ_SUB_EN.
- Defined: adds input port op_sub (1 bit), sampled at accept.
  - When op_sub=1: B register is loaded with ~in_b and the carry register with 1 (in_cin ignored), so the result is A-B.
  - out_cout = NOT borrow.
  - out_ovf uses the inverted-B sign.
- Undefined: no op_sub port; addition only.

Test Plan:
- WIDTH=16, A=0x1234, B=0x4321, cin=0 -> out_sum=0x5555, cout=0, ovf=0; out_valid 4 edges after accept.
- A=0xFFFF, B=0x0001, cin=0 -> out_sum=0x0000, cout=1, ovf=0; carry ripples across all 4 nibbles.
- A=0x7FFF, B=0x0000, cin=1 -> out_sum=0x8000, cout=0, ovf=1.
- Backpressure: out_ready=0 for 6 cycles after out_valid -> out_sum, out_cout and out_ovf stable and in_ready=0 throughout; in_ready=1 on the cycle after the out_ready handshake.
- Assert rst_n=0 after 2 RUN edges -> all outputs 0 and in_ready=1 immediately. The next op A=0x0F0F, B=0x00F1 -> 0x1000.
- CLA_SEQ_SUB_EN defined: A=0x0005, B=0x0007, op_sub=1 -> out_sum=0xFFFE, cout=0, ovf=0. With A=0x8000, B=0x0001, op_sub=1 -> 0x7FFF, ovf=1.
